tdm_demux: RTL
==============

# tdm_demux

Serial-to-parallel time-division demultiplexer: the receive-side counterpart of the team's mux tree. One bit per valid cycle is routed to the next channel slot under an internal rotating channel counter. A complete frame of N_CH bits is presented in parallel with a valid/ready handshake. The block sits between a serial link or TDM bus and downstream per-channel logic, and its channel index output mirrors the `sel` a remote mux uses to scan its inputs.

## Interface
Parameters:
- N_CH, 16, number of channels (power of two, 2..16)
- SEL_W, 4, channel index width; must equal log2(N_CH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_bit  in  1  serial data bit
- in_valid  in  1  in_bit is valid this cycle
- sync  in  1  qualified by in_valid; marks in_bit as channel 0 of a new frame
- sel  out  SEL_W  channel index the next valid bit will be written to
- frame  out  N_CH  last completed frame; bit i = channel i
- frame_valid  out  1  frame holds an unconsumed frame
- frame_ready  in  1  downstream accepts frame when frame_valid=1
- resync  out  1  one-cycle pulse: sync arrived with sel!=0 (partial frame dropped)
- ovf  out  1  sticky: a completed frame overwrote an unconsumed frame

## Operation
- Internal accumulator acc[N_CH-1:0] and channel counter ch (driven on sel).
- Cycle with in_valid=0: acc and ch hold. The handshake still operates.
- in_valid=1, sync=0: acc[ch] <= in_bit; ch <= ch+1, wrapping N_CH-1 -> 0.
- in_valid=1, sync=1: acc[0] <= in_bit; acc[N_CH-1:1] <= 0; ch <= 1. If ch!=0 at that edge, resync=1 for one cycle and the partial frame is discarded.
- Frame completion: an in_valid=1, sync=0 write with ch=N_CH-1 completes a frame.
  - On that edge: frame <= {in_bit, acc[N_CH-2:0]}; frame_valid <= 1; ch <= 0.
- Handshake: frame_valid=1 and frame_ready=1 at an edge consumes the frame. frame_valid clears unless a completion occurs on the same edge.
- Completion while frame_valid=1 and frame_ready=0: frame is overwritten, frame_valid stays 1, and ovf sets and holds until rst.
- Completion with frame_ready=1 on the same edge: the new frame loads, frame_valid stays 1, and ovf is unaffected.
- sync and a completion cannot coincide, because sync forces a channel-0 write.
- frame holds its value between completions. It is not cleared on consume.

## Timing
- Reset values: sel=0, frame=0, frame_valid=0, resync=0, ovf=0, acc=0.
- rst mid-frame discards the partial frame. The first valid bit after rst deasserts goes to channel 0.
- rst has priority over all other inputs in the same cycle.
- sel updates on the edge that samples a valid bit, so sel always names the slot for the next bit.
- Latency: the last bit of a frame is sampled at edge E, and frame/frame_valid are visible the cycle after E.
- Throughput: one bit per cycle, back-to-back frames with no gap. Sustained rate is one frame per N_CH valid cycles.
- resync is a registered pulse, high for exactly the cycle following the offending edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Basic frame:** reset, then 16 valid bits of 0xA5C3, LSB first with sync on the first bit, frame_ready=1 → frame=16'hA5C3 and frame_valid=1 for one cycle. sel steps 0,1,...,15,0.
- **Gapped input:** the same 16 bits with in_valid=0 inserted every other cycle → sel holds during the gaps and the result is identical, frame=16'hA5C3.
- **Resync:** 5 bits, then sync with in_bit=1 followed by 15 bits of 0 → resync pulses once, the partial frame is dropped, and frame=16'h0001.
- **Backpressure / overflow:** two back-to-back frames 0x1234 then 0xFFFF with frame_ready=0 → frame=16'hFFFF, frame_valid=1, ovf=1 and stays 1.
- **Consume on completion edge:** frame_ready=1 on the exact edge the second frame completes → frame_valid stays 1, ovf=0.
- **Reset mid-frame:** assert rst after 7 bits → all outputs return to reset values, and the next 16 bits form the frame from channel 0.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: serial-to-parallel TDM demultiplexer.
//
// One valid serial bit per cycle is written into the channel slot named by an
// internal rotating counter. A full frame of N_CH bits is then presented in
// parallel under a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_bit       serial data bit
//   in_valid     in_bit is valid this cycle
//   sync         (with in_valid) in_bit is channel 0 of a new frame
//   sel          channel slot the next valid bit will be written to
//   frame        last completed frame, bit i = channel i
//   frame_valid  frame holds an unconsumed frame
//   frame_ready  downstream accepts frame while frame_valid=1
//   resync       one-cycle pulse: sync arrived mid-frame, partial frame dropped
//   ovf          sticky: a completed frame overwrote an unconsumed one

package tdm_demux_pkg;
  // One serial beat as seen by every channel slot.
  typedef struct packed {
    logic valid;
    logic sync;
    logic data;
  } beat_t;
endpackage

// Per-channel slot: one accumulator bit plus its frame output bit.
module tdm_demux_slot
  import tdm_demux_pkg::*;
#(
  parameter bit FIRST = 1'b0   // slot is channel 0 (captures the sync bit)
) (
  input  logic  clk,
  input  logic  rst,
  input  beat_t beat,
  input  logic  hit,        // channel counter points at this slot
  input  logic  complete,   // the current beat completes a frame
  output logic  frame_bit
);
  logic acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (beat.valid) begin
      // sync restarts the frame: channel 0 takes the bit, all others clear.
      if (beat.sync)  acc <= FIRST ? beat.data : 1'b0;
      else if (hit)   acc <= beat.data;
    end
  end

  // On completion only the last slot is hit; it takes the live bit because
  // its accumulator has not captured it yet.
  always_ff @(posedge clk) begin
    if (rst)           frame_bit <= 1'b0;
    else if (complete) frame_bit <= hit ? beat.data : acc;
  end
endmodule

module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             resync,
  output logic             ovf
);
  beat_t            beat;
  logic [SEL_W-1:0] ch;
  logic [N_CH-1:0]  hit;
  logic             last_ch;
  logic             complete;

  assign beat     = '{valid: in_valid, sync: sync, data: in_bit};
  assign last_ch  = (ch == SEL_W'(N_CH - 1));
  // A sync beat always writes channel 0, so it can never complete a frame.
  assign complete = in_valid & ~sync & last_ch;
  assign sel      = ch;

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    assign hit[g] = (ch == SEL_W'(g));
    tdm_demux_slot #(.FIRST(g == 0)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .beat      (beat),
      .hit       (hit[g]),
      .complete  (complete),
      .frame_bit (frame[g])
    );
  end

  // Channel counter: sync jumps to 1 since its own bit already filled slot 0.
  always_ff @(posedge clk) begin
    if (rst)              ch <= '0;
    else if (in_valid) begin
      if (sync)           ch <= SEL_W'(1);
      else if (last_ch)   ch <= '0;
      else                ch <= ch + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      ovf         <= 1'b0;
      resync      <= 1'b0;
    end else begin
      resync <= in_valid & sync & (ch != '0);
      // A completion keeps frame_valid high even if the old frame is consumed
      // on the same edge; only an unconsumed overwrite counts as overflow.
      if (complete) begin
        frame_valid <= 1'b1;
        if (frame_valid && !frame_ready) ovf <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end
endmodule
